// File: rtl/brick_scan_pkg.sv
// rtl/brick_scan_pkg.sv - shared brick defaults and brick_scan state encodings
package brick_scan_pkg;

  localparam int          BRICKNUM  = 64;
  localparam logic [19:0] BRICKDRAW = 20'd40;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_READ     = 3'd2,
    S_DRAWPREP = 3'd3,
    S_DRAW     = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6
  } scan_state_t;

endpackage

// File: rtl/brick_scan_if.sv
// rtl/brick_scan_if.sv - game-FSM / brick-RAM / drawer side bundle of brick_scan
interface brick_scan_if #(parameter int ADDR_W = 10);

  logic              start;
  logic              redraw_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_health;
  logic              draw;
  logic [9:0]        x_out;
  logic [9:0]        y_out;
  logic [1:0]        health_out;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   live_count;
  logic              cleared;

  modport master (
    output start, redraw_en, rd_health,
    input  rd_addr, draw, x_out, y_out, health_out, busy, done, live_count, cleared
  );

  modport slave (
    input  start, redraw_en, rd_health,
    output rd_addr, draw, x_out, y_out, health_out, busy, done, live_count, cleared
  );

endinterface

// File: rtl/address_xy.sv
// rtl/address_xy.sv - brick slot address to pixel position (16 bricks per row)
module address_xy (
  input  logic [9:0] i_addr,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  // 40x16 pixel bricks, playfield starts 32 lines below the top
  assign o_x = 10'(i_addr[3:0]) * 10'd40;
  assign o_y = {i_addr[9:4], 4'b0000} + 10'd32;

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - free-running enable counter with synchronous active-low clear
module counter #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         i_resetn,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_resetn)
      r_count <= '0;
    else if (i_en)
      r_count <= r_count + W'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/brick_scan.sv
// rtl/brick_scan.sv - brick RAM walker: counts live bricks and optionally re-issues draws
module brick_scan_control import brick_scan_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_live,
  input  logic        i_redraw,
  input  logic        i_last,
  input  logic        i_delay_done,
  output scan_state_t o_state
);

  scan_state_t r_state;
  scan_state_t w_next;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = S_ADDR;
      S_ADDR:     w_next = S_READ;
      S_READ:     w_next = (i_live && i_redraw) ? S_DRAWPREP : S_NEXT;
      S_DRAWPREP: w_next = S_DRAW;
      S_DRAW:     if (i_delay_done) w_next = S_NEXT;
      S_NEXT:     w_next = i_last ? S_DONE : S_ADDR;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

module brick_scan_datapath import brick_scan_pkg::*; #(
  parameter int          BRICK_NUM  = BRICKNUM,
  parameter logic [19:0] DRAW_DELAY = BRICKDRAW,
  parameter int          ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  scan_state_t       i_state,
  input  logic              i_start,
  input  logic              i_redraw_en,
  input  logic [1:0]        i_rd_health,
  output logic [ADDR_W-1:0] o_idx,
  output logic [1:0]        o_health,
  output logic [ADDR_W:0]   o_live_count,
  output logic              o_cleared,
  output logic              o_redraw,
  output logic              o_live,
  output logic              o_last,
  output logic              o_delay_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BRICK_NUM - 1);

  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_health;
  logic [ADDR_W:0]   r_live_count;
  logic              r_cleared;
  logic              r_redraw;
  logic [19:0]       w_delay;
  logic              w_cnt_resetn;
  logic              w_last;

  // delay counter is held clear outside DRAW so each brick starts from zero
  assign w_cnt_resetn = ~reset & (i_state != S_NEXT);

  counter #(.W(20)) u_delay (
    .clk      (clk),
    .i_resetn (w_cnt_resetn),
    .i_en     (i_state == S_DRAW),
    .o_count  (w_delay)
  );

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_count      <= '0;
      r_health     <= 2'd0;
      r_live_count <= '0;
      r_cleared    <= 1'b0;
      r_redraw     <= 1'b0;
    end else begin
      case (i_state)
        S_IDLE: if (i_start) begin
          r_idx    <= '0;
          r_count  <= '0;
          r_redraw <= i_redraw_en;
        end
        S_READ: begin
          r_health <= i_rd_health;
          if (i_rd_health != 2'd0)
            r_count <= r_count + (ADDR_W+1)'(1);
        end
        S_NEXT: if (!w_last) r_idx <= r_idx + ADDR_W'(1);
        S_DONE: begin
          r_live_count <= r_count;
          r_cleared    <= (r_count == '0);
        end
        default: ;
      endcase
    end
  end

  assign o_idx        = r_idx;
  assign o_health     = r_health;
  assign o_live_count = r_live_count;
  assign o_cleared    = r_cleared;
  assign o_redraw     = r_redraw;
  assign o_live       = (i_rd_health != 2'd0);
  assign o_last       = w_last;
  assign o_delay_done = (w_delay == DRAW_DELAY);

endmodule

module brick_scan import brick_scan_pkg::*; #(
  parameter int          BRICK_NUM  = BRICKNUM,
  parameter logic [19:0] DRAW_DELAY = BRICKDRAW,
  parameter int          ADDR_W     = 10
) (
  input logic         clk,
  input logic         reset,
  brick_scan_if.slave bus
);

  scan_state_t       w_state;
  logic [ADDR_W-1:0] w_idx;
  logic              w_redraw;
  logic              w_live;
  logic              w_last;
  logic              w_delay_done;

  brick_scan_control u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .i_start      (bus.start),
    .i_live       (w_live),
    .i_redraw     (w_redraw),
    .i_last       (w_last),
    .i_delay_done (w_delay_done),
    .o_state      (w_state)
  );

  brick_scan_datapath #(
    .BRICK_NUM  (BRICK_NUM),
    .DRAW_DELAY (DRAW_DELAY),
    .ADDR_W     (ADDR_W)
  ) u_dp (
    .clk          (clk),
    .reset        (reset),
    .i_state      (w_state),
    .i_start      (bus.start),
    .i_redraw_en  (bus.redraw_en),
    .i_rd_health  (bus.rd_health),
    .o_idx        (w_idx),
    .o_health     (bus.health_out),
    .o_live_count (bus.live_count),
    .o_cleared    (bus.cleared),
    .o_redraw     (w_redraw),
    .o_live       (w_live),
    .o_last       (w_last),
    .o_delay_done (w_delay_done)
  );

  // idx doubles as the RAM address, so it holds until NEXT advances it
  assign bus.rd_addr = w_idx;
  assign bus.draw    = (w_state == S_DRAWPREP);
  assign bus.busy    = (w_state != S_IDLE) && (w_state != S_DONE);
  assign bus.done    = (w_state == S_DONE);

  address_xy u_xy (
    .i_addr (w_idx),
    .o_x    (bus.x_out),
    .o_y    (bus.y_out)
  );

endmodule

// File: tb/tb_brick_scan.sv
// tb/tb_brick_scan.sv - randomized scans of three brick_scan instances against a scan-schedule model
module tb_brick_scan;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  brick_scan_if #(.ADDR_W(10)) if_a ();
  brick_scan_if #(.ADDR_W(10)) if_b ();
  brick_scan_if #(.ADDR_W(10)) if_c ();

  brick_scan u_a (.clk(clk), .reset(reset), .bus(if_a));
  brick_scan #(.BRICK_NUM(8), .DRAW_DELAY(20'd3), .ADDR_W(10)) u_b (.clk(clk), .reset(reset), .bus(if_b));
  brick_scan #(.BRICK_NUM(1023), .DRAW_DELAY(20'd2), .ADDR_W(10)) u_c (.clk(clk), .reset(reset), .bus(if_c));

  logic       start_s [3];
  logic       redraw_s[3];
  logic [1:0] mem     [3][1024];
  logic       busy_s[3], done_s[3], draw_s[3], clr_s[3];
  logic [9:0] addr_s[3], x_s[3], y_s[3];
  logic [1:0] h_s[3];
  logic [10:0] live_s[3];

  assign if_a.start = start_s[0]; assign if_a.redraw_en = redraw_s[0];
  assign if_b.start = start_s[1]; assign if_b.redraw_en = redraw_s[1];
  assign if_c.start = start_s[2]; assign if_c.redraw_en = redraw_s[2];

  assign busy_s[0] = if_a.busy; assign done_s[0] = if_a.done; assign draw_s[0] = if_a.draw; assign clr_s[0] = if_a.cleared;
  assign busy_s[1] = if_b.busy; assign done_s[1] = if_b.done; assign draw_s[1] = if_b.draw; assign clr_s[1] = if_b.cleared;
  assign busy_s[2] = if_c.busy; assign done_s[2] = if_c.done; assign draw_s[2] = if_c.draw; assign clr_s[2] = if_c.cleared;
  assign addr_s[0] = if_a.rd_addr; assign x_s[0] = if_a.x_out; assign y_s[0] = if_a.y_out;
  assign addr_s[1] = if_b.rd_addr; assign x_s[1] = if_b.x_out; assign y_s[1] = if_b.y_out;
  assign addr_s[2] = if_c.rd_addr; assign x_s[2] = if_c.x_out; assign y_s[2] = if_c.y_out;
  assign h_s[0] = if_a.health_out; assign live_s[0] = if_a.live_count;
  assign h_s[1] = if_b.health_out; assign live_s[1] = if_b.live_count;
  assign h_s[2] = if_c.health_out; assign live_s[2] = if_c.live_count;

  // synchronous brick RAM, one cycle read latency
  always @(posedge clk) begin
    if_a.rd_health <= mem[0][if_a.rd_addr];
    if_b.rd_health <= mem[1][if_b.rd_addr];
    if_c.rd_health <= mem[2][if_c.rd_addr];
  end

  int nn[3] = '{64, 8, 1023};
  int dd[3] = '{40, 3, 2};
  int lvl[6] = '{3, 1, 3, 3, 2, 1};

  bit         exp_draw[8192];
  logic [1:0] exp_h   [8192];
  int         exp_addr[8192];
  int         done_t, exp_live;
  int         last_live[3];
  int         seen[$];
  int         max_addr;
  int         n_chk = 0;
  int         n_fail = 0;

  function automatic int xm(input int a);
    return (a % 16) * 40;
  endfunction

  function automatic int ym(input int a);
    return ((a / 16) * 16 + 32) % 1024;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // schedule of a scan: cycle 1 is the first cycle after the start cycle
  task automatic build_model(input int k, input bit rd);
    int t;
    int len;
    logic [1:0] h;
    t = 1;
    exp_live = 0;
    for (int i = 0; i < nn[k]; i++) begin
      h = mem[k][i];
      if (h != 2'd0) exp_live++;
      len = (h != 2'd0 && rd) ? dd[k] + 5 : 3;
      for (int j = 0; j < len; j++) begin
        exp_addr[t+j] = i;
        exp_h[t+j]    = h;
        exp_draw[t+j] = (h != 2'd0) && rd && (j == 2);
      end
      t += len;
    end
    done_t = t;
  endtask

  task automatic check_cycle(input int k, input int c);
    bit last;
    last = (c == done_t);
    chk("busy", busy_s[k], !last);
    chk("done", done_s[k], last);
    chk("draw", draw_s[k], last ? 0 : exp_draw[c]);
    chk("rd_addr", addr_s[k], last ? nn[k] - 1 : exp_addr[c]);
    chk("live_hold", live_s[k], last_live[k]);
    if (draw_s[k]) seen.push_back(h_s[k]);
    if (addr_s[k] > max_addr) max_addr = addr_s[k];
    if (!last && exp_draw[c]) begin
      chk("health_out", h_s[k], exp_h[c]);
      chk("x_out", x_s[k], xm(exp_addr[c]));
      chk("y_out", y_s[k], ym(exp_addr[c]));
    end
  endtask

  task automatic run_scan(input int k, input bit rd, input int extra);
    int ex;
    build_model(k, rd);
    ex = extra;
    if (ex < 0) ex = ($urandom % 2) ? int'($urandom_range(1, done_t)) : 0;
    seen.delete();
    max_addr = 0;
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    redraw_s[k] = rd;
    for (int c = 1; c <= done_t; c++) begin
      @(posedge clk); #1;
      start_s[k] = (c == ex);
      redraw_s[k] = 1'($urandom);
      @(negedge clk);
      check_cycle(k, c);
    end
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    @(negedge clk);
    chk("busy_after", busy_s[k], 0);
    chk("done_after", done_s[k], 0);
    chk("live_count", live_s[k], exp_live);
    chk("cleared", clr_s[k], exp_live == 0);
    last_live[k] = exp_live;
  endtask

  task automatic idle_check(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy_s[k], 0);
      chk("idle_done", done_s[k], 0);
    end
  endtask

  task automatic load_level1();
    for (int i = 0; i < 1024; i++) mem[0][i] = 2'd0;
    mem[0][1] = 2'd3; mem[0][2] = 2'd1; mem[0][3] = 2'd3;
    mem[0][4] = 2'd3; mem[0][5] = 2'd2; mem[0][33] = 2'd1;
  endtask

  task automatic random_fill(input int k);
    int p;
    p = $urandom_range(0, 100);
    for (int i = 0; i < 1024; i++)
      mem[k][i] = (int'($urandom % 100) < p) ? 2'($urandom_range(1, 3)) : 2'd0;
  endtask

  task automatic reset_mid_scan();
    int tgt;
    load_level1();
    build_model(0, 1'b1);
    tgt = 0;
    for (int c = 1; c < done_t; c++)
      if (exp_draw[c] && exp_addr[c] == 5) tgt = c + 3;
    chk("model_reset_tgt", tgt, 189);
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    redraw_s[0] = 1'b1;
    for (int c = 1; c <= tgt; c++) begin
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      @(negedge clk);
      check_cycle(0, c);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_s[0], 0);
    chk("rst_draw", draw_s[0], 0);
    chk("rst_done", done_s[0], 0);
    chk("rst_live", live_s[0], 0);
    chk("rst_addr", addr_s[0], 0);
    for (int k = 0; k < 3; k++) last_live[k] = 0;
    idle_check(0, 20);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      redraw_s[k] = 1'b0;
      last_live[k] = 0;
      for (int i = 0; i < 1024; i++) mem[k][i] = 2'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", busy_s[k], 0);
      chk("reset_draw", draw_s[k], 0);
      chk("reset_done", done_s[k], 0);
      chk("reset_addr", addr_s[k], 0);
      chk("reset_health", h_s[k], 0);
      chk("reset_live", live_s[k], 0);
      chk("reset_cleared", clr_s[k], 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_scan(1, 1'b0, 0);
    chk("empty_done_cycle", done_t, 25);
    chk("empty_draws", seen.size(), 0);
    chk("empty_cleared", clr_s[1], 1);

    load_level1();
    run_scan(0, 1'b1, 0);
    chk("lvl1_draw_count", seen.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < seen.size()) chk("lvl1_draw_health", seen[i], lvl[i]);
    chk("lvl1_live", live_s[0], 6);
    chk("lvl1_redraw_done_cycle", done_t, 445);

    run_scan(0, 1'b0, 0);
    chk("lvl1_nodraw_done_cycle", done_t, 193);
    chk("lvl1_nodraw_draws", seen.size(), 0);
    chk("lvl1_nodraw_cleared", clr_s[0], 0);

    run_scan(0, 1'b0, 50);
    idle_check(0, 5);
    run_scan(0, 1'b1, 100);
    chk("busy_start_live", live_s[0], 6);
    idle_check(0, 5);

    reset_mid_scan();
    run_scan(0, 1'b1, 0);
    chk("after_reset_live", live_s[0], 6);

    for (int i = 0; i < 1024; i++) mem[2][i] = 2'($urandom_range(1, 3));
    run_scan(2, 1'b0, 0);
    chk("full_live", live_s[2], 1023);
    chk("full_max_addr", max_addr, 1022);

    for (int r = 0; r < 6; r++) begin
      random_fill(0);
      run_scan(0, 1'($urandom), -1);
    end
    for (int r = 0; r < 6; r++) begin
      random_fill(1);
      run_scan(1, 1'($urandom), -1);
    end
    random_fill(2);
    run_scan(2, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_scan.md
Name: brick_scan

Overview:
- Reader at the other end of the brick-memory write path: walks the brick RAM filled by the level loader, reads each brick's 2-bit health, and counts live bricks.
- Optionally re-emits a draw request per live brick for the VGA drawer, with the same draw/settle pacing the loader uses.
- Sits between the brick RAM read port and the top-level game FSM, which uses it for redraw after a life is lost and for the level-cleared check.

Parameters:
- BRICK_NUM, 64, number of brick slots scanned, addresses 0..BRICK_NUM-1; legal range 1..1023.
- DRAW_DELAY, 20'd40, cycles held in DRAW per live brick so the drawer can finish.
- ADDR_W, 10, brick RAM address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- redraw_en  in  1  sampled with start; 1 = emit draw requests for live bricks.
- rd_addr  out  ADDR_W  brick RAM read address.
- rd_health  in  2  RAM read data, valid exactly 1 cycle after rd_addr is presented.
- draw  out  1  one-cycle pulse: drawer should latch x_out/y_out/health_out.
- x_out  out  10  pixel x of the current brick.
- y_out  out  10  pixel y of the current brick.
- health_out  out  2  captured health of the current brick; selects colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a scan.
- live_count  out  ADDR_W+1  number of bricks with health!=0 from the last completed scan.
- cleared  out  1  live_count==0; valid once done has pulsed.

Behaviour:
- Reset, from any state: go to IDLE. rd_addr=0, draw=0, busy=0, done=0, health_out=0, live_count=0, cleared=0. Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, ADDR, READ, DRAWPREP, DRAW, NEXT, DONE.
  - IDLE: on start=1, clear idx and the running count, latch redraw_en, go to ADDR. A start pulse outside IDLE is ignored.
  - ADDR: drive rd_addr=idx, go to READ. This is the RAM latency cycle.
  - READ: capture rd_health into health_out. If it is nonzero, running count +1. If nonzero and redraw was latched, go to DRAWPREP; otherwise go to NEXT.
  - DRAWPREP: draw=1 for exactly this cycle, then go to DRAW.
  - DRAW: a delay counter starts at 0 and increments each cycle. Go to NEXT when the counter reaches DRAW_DELAY; the counter is cleared on exit.
  - NEXT: if idx==BRICK_NUM-1, go to DONE; else idx+1 and go to ADDR.
  - DONE: done=1 for one cycle, live_count takes the running count, go to IDLE.
- Timing:
  - Per brick: 3 cycles without a draw; DRAW_DELAY+5 cycles with a draw.
  - Full scan with no draws: 3*BRICK_NUM+1 cycles from the cycle after start to done.
- rd_addr holds its value through READ/DRAWPREP/DRAW/NEXT.
- x_out/y_out are derived combinationally from rd_addr through the existing address-to-xy mapping. They are valid and stable whenever draw=1.
- live_count and cleared update only in DONE; they hold their previous values while busy.
- busy is high in every state except IDLE and DONE.
- Health value 0 means no brick. Health values 1..3 are all live; their magnitude is not counted.
- Widths:
  - idx is ADDR_W bits and never wraps, because it stops at BRICK_NUM-1.
  - The running count is ADDR_W+1 bits, so BRICK_NUM=1023 with all bricks live cannot overflow.
- rd_addr is never driven at or beyond BRICK_NUM.

Decomposition:
- Shared macros header (existing): BRICKNUM and BRICKDRAW feed the BRICK_NUM and DRAW_DELAY defaults. Add the state encodings for brick_scan.
- Sub-module: reuse the existing address_xy for the address-to-pixel conversion. Do not duplicate it.
- Counters: reuse the existing counter module for the DRAW delay, with its reset = ~reset & ~(state==NEXT).
- FSM and datapath stay in one file as brick_scan_control and brick_scan_datapath.

Test Plan:
- Reset mid-scan: assert reset in DRAW at idx=5 -> next cycle busy=0, draw=0, live_count=0, no done pulse; a later start scans from address 0.
- Empty RAM, BRICK_NUM=8, redraw_en=0, start -> done pulses exactly 25 cycles after the start cycle, live_count=0, cleared=1, draw never asserted.
- Level-one pattern (addr1=3, 2=1, 3=3, 4=3, 5=2, 33=1), BRICK_NUM=64, redraw_en=1 -> six draw pulses with health_out 3,1,3,3,2,1; each draw's x_out/y_out match address_xy; live_count=6, cleared=0.
- Same pattern, redraw_en=0 -> no draws, live_count=6, done at cycle 193.
- start pulsed again while busy -> ignored; a single done pulse; live_count unchanged from a clean single scan.
- Address bound, BRICK_NUM=1023 with all bricks live and no redraw -> live_count=1023, rd_addr maximum is 1022.
